// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types, constants and command helpers for the frontend request arbiter
package arbiter_pkg;

  localparam int NUM_REQ_MAX    = 8;
  localparam int DQ_BITS        = 8;
  localparam int ROW_BITS       = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_TAG_DEPTH  = 8;
  localparam int DEF_MAX_BYPASS = 4;

  typedef logic [$clog2(NUM_REQ_MAX)-1:0] req_id_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_READ    = 2'd1,
    OP_WRITE   = 2'd2,
    OP_REFRESH = 2'd3
  } op_type_t;

  typedef struct packed {
    op_type_t            op_type;
    logic [3:0]          bank;
    logic [ROW_BITS-1:0] row_addr;
    logic [9:0]          col_addr;
  } frontend_command_t;

  localparam int FRONTEND_CMD_BITS = $bits(frontend_command_t);

  function automatic logic is_read(input frontend_command_t cmd);
    return cmd.op_type == OP_READ;
  endfunction

  function automatic logic [ROW_BITS-1:0] row_of(input frontend_command_t cmd);
    return cmd.row_addr;
  endfunction

endpackage

// File: rtl/return_tag_fifo.sv
// rtl/return_tag_fifo.sv - in-order FIFO of requester IDs waiting for backend read data
module return_tag_fifo
  import arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  req_id_t                push_id,
  input  logic                   pop,
  output req_id_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  req_id_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frontend_request_arbiter.sv
// rtl/frontend_request_arbiter.sv - round-robin command arbiter with read-return routing
// ARB_ROW_HIT_PRIORITY_EN adds row-hit priority bounded by a bypass counter
module frontend_request_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CMD_W     = FRONTEND_CMD_BITS,
  parameter int DATA_W    = DQ_BITS * 8,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
`ifdef ARB_ROW_HIT_PRIORITY_EN
  ,
  parameter int MAX_BYPASS = DEF_MAX_BYPASS
`endif
) (
  input  logic                          clk,
  input  logic                          power_on_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*CMD_W-1:0]      req_cmd,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [NUM_REQ-1:0]            req_rdata_valid,
  input  logic [NUM_REQ-1:0]            req_rdata_ready,
  output logic                          be_cmd_valid,
  input  logic                          be_cmd_ready,
  output logic [CMD_W-1:0]              be_cmd,
  output logic [DATA_W-1:0]             be_wdata,
  input  logic [DATA_W-1:0]             be_rdata,
  input  logic                          be_rdata_valid,
  output logic                          be_rdata_ready,
  output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
  output logic                          err_unexpected_rdata
);

  localparam int IDW = $bits(req_id_t);

  logic               stg_valid;
  logic               stage_free;
  logic               take;
  logic               grant_found;
  req_id_t            grant;
  req_id_t            rr_ptr;
  logic [IDW:0]       rr_sel;
  logic [NUM_REQ-1:0] eligible;
  logic [CMD_W-1:0]   grant_cmd;
  logic [DATA_W-1:0]  grant_wdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  req_id_t            fifo_head;
  logic               head_ready;

  // Returns {found, index} of the first set mask bit at or after ptr, wrapping at NUM_REQ.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] mask, input req_id_t ptr);
    logic [IDW:0]             sel;
    logic [NUM_REQ_MAX-1:0]   m;
    int                       s;
    req_id_t                  idx;
    sel = '0;
    m   = NUM_REQ_MAX'(mask);
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = req_id_t'(s);
      if (m[idx]) sel = {1'b1, idx};
    end
    return sel;
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] &
                    (!is_read(frontend_command_t'(req_cmd[i*CMD_W +: CMD_W])) | !fifo_full);
    end
  end

  assign rr_sel = rr_pick(eligible, rr_ptr);

`ifdef ARB_ROW_HIT_PRIORITY_EN
  localparam int BW = $clog2(MAX_BYPASS + 1);

  logic [NUM_REQ-1:0]  hit_mask;
  logic [IDW:0]        hit_sel;
  logic [ROW_BITS-1:0] last_row;
  logic [BW-1:0]       bypass_cnt;
  logic                force_rr;
  logic                use_hit;

  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hit_mask[i] = eligible[i] &
                    (row_of(frontend_command_t'(req_cmd[i*CMD_W +: CMD_W])) == last_row);
    end
  end

  assign hit_sel     = rr_pick(hit_mask, rr_ptr);
  assign force_rr    = bypass_cnt == BW'(MAX_BYPASS);
  assign use_hit     = hit_sel[IDW] & !force_rr;
  assign grant_found = rr_sel[IDW];
  assign grant       = use_hit ? hit_sel[IDW-1:0] : rr_sel[IDW-1:0];

  // Only a hit that overrides the round-robin choice counts as a bypass.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      last_row   <= '0;
      bypass_cnt <= '0;
    end else if (take) begin
      last_row <= row_of(frontend_command_t'(grant_cmd));
      if (force_rr) begin
        bypass_cnt <= '0;
      end else if (use_hit && (hit_sel[IDW-1:0] != rr_sel[IDW-1:0])) begin
        bypass_cnt <= bypass_cnt + 1'b1;
      end
    end
  end
`else
  assign grant_found = rr_sel[IDW];
  assign grant       = rr_sel[IDW-1:0];
`endif

  always_comb begin
    grant_cmd   = '0;
    grant_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_id_t'(i) == grant) begin
        grant_cmd   = req_cmd[i*CMD_W +: CMD_W];
        grant_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign stage_free = !stg_valid | be_cmd_ready;
  assign take       = stage_free & grant_found & !power_on_rst;
  assign fifo_push  = take & is_read(frontend_command_t'(grant_cmd));

  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      stg_valid <= 1'b0;
      be_cmd    <= '0;
      be_wdata  <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      stg_valid <= 1'b1;
      be_cmd    <= grant_cmd;
      be_wdata  <= grant_wdata;
      rr_ptr    <= (grant == req_id_t'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (be_cmd_ready) begin
      stg_valid <= 1'b0;
    end
  end

  assign be_cmd_valid = stg_valid;

  return_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (power_on_rst),
    .push    (fifo_push),
    .push_id (grant),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rd_outstanding)
  );

  always_comb begin
    head_ready      = 1'b0;
    req_ready       = '0;
    req_rdata_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_id_t'(i) == fifo_head) head_ready = req_rdata_ready[i];
      req_ready[i]       = take & (req_id_t'(i) == grant);
      req_rdata_valid[i] = be_rdata_valid & !fifo_empty & (req_id_t'(i) == fifo_head);
    end
  end

  assign be_rdata_ready = !fifo_empty & head_ready;
  assign fifo_pop       = be_rdata_valid & be_rdata_ready;
  assign req_rdata      = be_rdata;

  // Data with no tag to route it is dropped; the flag records that it happened.
  always_ff @(posedge clk) begin
    if (power_on_rst) begin
      err_unexpected_rdata <= 1'b0;
    end else if (be_rdata_valid & fifo_empty) begin
      err_unexpected_rdata <= 1'b1;
    end
  end

endmodule
